i2c_gpio_master: RTL

- Single-master I2C controller that sequences one-byte transactions to the I2C-to-GPIO port expander slave.
- Transaction types:
  - write: set expander outputs.
  - read: fetch expander inputs.
- Accepts a command over a valid/ready handshake.
- Generates START, 7-bit address + R/W, ACK slot, data byte, ACK/NACK slot, STOP.
- Drives SCL/SDA open-drain through output-enables and returns read data plus status.

---
 rtl/i2c_gpio_pkg.sv | 35 +++
 rtl/i2c_quarter_tick.sv | 45 ++++
 rtl/i2c_gpio_master.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/i2c_gpio_pkg.sv
// Shared types and constants for the single-byte I2C GPIO-expander master.
package i2c_gpio_pkg;

  // Transaction sequence, one entry per bit slot group.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StAddr,
    StAack,
    StData,
    StDack,
    StStop,
    StDone
  } state_e;

  // Quarter of a bit slot: SCL is low in Q0/Q1 and high in Q2/Q3.
  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_e;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  localparam int unsigned ADDR_BITS = 8;  // A6..A0 plus R/W
  localparam int unsigned DATA_BITS = 8;

  // SCL is pulled low during the first half of every ordinary bit slot.
  function automatic logic scl_low(quarter_e q);
    return (q == Q0) || (q == Q1);
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Divides clk into quarter-bit strobes and tracks which quarter is current.
module i2c_quarter_tick
  import i2c_gpio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     clr_i,      // restart at Q0 on the next cycle
  output logic     tick_o,     // last clk of the current quarter
  output quarter_e quarter_o
);

  localparam int unsigned DivW = $clog2(CLK_DIV);

  logic [DivW-1:0] div_q, div_d;
  quarter_e        qtr_q, qtr_d;
  logic            last;

  // Next divider count and quarter index.
  always_comb begin
    last  = (div_q == DivW'(CLK_DIV - 1));
    div_d = last ? '0 : div_q + 1'b1;
    qtr_d = last ? quarter_e'(qtr_q + 2'd1) : qtr_q;
    if (clr_i) begin
      div_d = '0;
      qtr_d = Q0;
    end
  end

  // Divider and quarter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      qtr_q <= Q0;
    end else begin
      div_q <= div_d;
      qtr_q <= qtr_d;
    end
  end

  assign tick_o    = last;
  assign quarter_o = qtr_q;

endmodule

// File: rtl/i2c_gpio_master.sv
// Single-master I2C controller issuing one-byte writes/reads to a GPIO expander.
module i2c_gpio_master
  import i2c_gpio_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 4,
  parameter logic [6:0]  DEF_ADDR = 7'h40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic       cmd_addr_sel,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic [7:0] rd_data,
  output logic       done,
  output logic       nack_err,
  output logic       busy,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_in
);

  state_e     state_q, state_d;
  logic [7:0] sh_q, sh_d;          // outgoing bits, MSB on the wire
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] rd_data_q, rd_data_d;
  logic [2:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic       nack_q, nack_d;

  logic       accept, tick, slot_end, sample;
  quarter_e   quarter;

  assign accept   = cmd_valid & cmd_ready;
  assign slot_end = tick & (quarter == Q3);
  assign sample   = tick & (quarter == Q2);

  i2c_quarter_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (accept),
    .tick_o   (tick),
    .quarter_o(quarter)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state: advance at slot boundaries; an address NACK skips the data phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StStart;
      StStart: if (slot_end) state_d = StAddr;
      StAddr:  if (slot_end && cnt_q == 3'(ADDR_BITS - 1)) state_d = StAack;
      StAack:  if (slot_end) state_d = nack_q ? StStop : StData;
      StData:  if (slot_end && cnt_q == 3'(DATA_BITS - 1)) state_d = StDack;
      StDack:  if (slot_end) state_d = StStop;
      StStop:  if (slot_end) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: command latch, bit shifting, SDA sampling and status.
  always_comb begin
    sh_d      = sh_q;
    wdata_d   = wdata_q;
    rx_d      = rx_q;
    rd_data_d = rd_data_q;
    cnt_d     = cnt_q;
    rw_d      = rw_q;
    nack_d    = nack_q;
    if (accept) begin
      sh_d    = {(cmd_addr_sel ? cmd_addr : DEF_ADDR), cmd_rw};
      wdata_d = cmd_wdata;
      rw_d    = cmd_rw;
      cnt_d   = '0;
      nack_d  = 1'b0;
    end
    if (sample) begin
      case (state_q)
        StData:  rx_d = {rx_q[6:0], sda_in};
        StAack:  if (sda_in) nack_d = 1'b1;
        // A read ends with our own NACK, so only a write checks the data ACK.
        StDack:  if (sda_in && rw_q == RW_WRITE) nack_d = 1'b1;
        default: ;
      endcase
    end
    if (slot_end) begin
      case (state_q)
        StAddr, StData: begin
          sh_d  = {sh_q[6:0], 1'b0};
          cnt_d = cnt_q + 3'd1;  // wraps to 0 after the 8th bit
          if (state_q == StData && cnt_q == 3'(DATA_BITS - 1) && rw_q == RW_READ) begin
            rd_data_d = rx_q;
          end
        end
        StAack:  sh_d = wdata_q;
        default: ;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q      <= '0;
      wdata_q   <= '0;
      rx_q      <= '0;
      rd_data_q <= '0;
      cnt_q     <= '0;
      rw_q      <= RW_WRITE;
      nack_q    <= 1'b0;
    end else begin
      sh_q      <= sh_d;
      wdata_q   <= wdata_d;
      rx_q      <= rx_d;
      rd_data_q <= rd_data_d;
      cnt_q     <= cnt_d;
      rw_q      <= rw_d;
      nack_q    <= nack_d;
    end
  end

  // Outputs: open-drain enables per state and quarter, plus handshake/status.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_q)
      StStart: begin
        sda_oe = (quarter == Q2) || (quarter == Q3);
        scl_oe = (quarter == Q3);
      end
      StAddr: begin
        scl_oe = scl_low(quarter);
        sda_oe = ~sh_q[7];
      end
      StData: begin
        scl_oe = scl_low(quarter);
        sda_oe = (rw_q == RW_WRITE) ? ~sh_q[7] : 1'b0;
      end
      StAack, StDack: scl_oe = scl_low(quarter);
      StStop: begin
        sda_oe = (quarter == Q0) || (quarter == Q1);
        scl_oe = (quarter == Q0);
      end
      default: ;
    endcase
    cmd_ready = (state_q == StIdle);
    busy      = (state_q != StIdle) && (state_q != StDone);
    done      = (state_q == StDone);
    nack_err  = nack_q;
    rd_data   = rd_data_q;
  end

endmodule
